// File: rtl/wash_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wash_start_ctrl
// Brief    : Front-end controller for the washing-machine FSM. Debounces the
//            start button and door sensor, sequences the door lock and the
//            start handshake, detects end-of-cycle from the FSM state, counts
//            completed washes and reports door-forced / start-timeout faults.
// Revision : 1.0 - initial release
// ============================================================================
module wash_start_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCK_SETTLE     = 4,
  parameter int UNLOCK_DELAY    = 8,
  parameter int START_TIMEOUT   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn_raw,
  input  logic       door_sensor_raw,
  input  logic [1:0] machine_state,
  output logic       start,
  output logic       door_closed,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [7:0] cycles_done
);

  // Controller states
  localparam logic [2:0] CTRL_IDLE   = 3'd0;
  localparam logic [2:0] CTRL_LOCK   = 3'd1;
  localparam logic [2:0] CTRL_START  = 3'd2;
  localparam logic [2:0] CTRL_RUN    = 3'd3;
  localparam logic [2:0] CTRL_UNLOCK = 3'd4;
  localparam logic [2:0] CTRL_FAULT  = 3'd5;

  // Machine FSM states of interest
  localparam logic [1:0] C_MS_IDLE = 2'b00;
  localparam logic [1:0] C_MS_SPIN = 2'b11;

  // Fault codes
  localparam logic [1:0] C_CODE_NONE    = 2'b00;
  localparam logic [1:0] C_CODE_DOOR    = 2'b01;
  localparam logic [1:0] C_CODE_TIMEOUT = 2'b10;

  // Shared per-state counter; wide enough for any sane timing parameter
  localparam int              CNT_W           = 16;
  localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_SETTLE_LAST  = CNT_W'(LOCK_SETTLE - 1);
  localparam logic [CNT_W-1:0] C_UNLOCK_LAST  = CNT_W'(UNLOCK_DELAY - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [7:0]       C_DEB_LIMIT    = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0]       C_CYCLES_MAX   = 8'd255;

  // Bit 0 = start button, bit 1 = door sensor
  logic [1:0] w_raw;
  logic [1:0] w_stable;

  assign w_raw = {door_sensor_raw, start_btn_raw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [7:0] r_db_cnt;
    logic       r_db_stable;

    // Accept a raw value only after it has disagreed with the stable value long enough
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_db_cnt    <= 8'd0;
        r_db_stable <= 1'b0;
      end else if (w_raw[gi] == r_db_stable) begin
        r_db_cnt    <= 8'd0;
      end else if (r_db_cnt == C_DEB_LIMIT) begin
        r_db_stable <= w_raw[gi];
        r_db_cnt    <= 8'd0;
      end else begin
        r_db_cnt    <= r_db_cnt + 8'd1;
      end
    end

    assign w_stable[gi] = r_db_stable;
  end

  logic       r_start_prev;
  logic [1:0] r_prev_ms;
  logic       w_start_evt;
  logic       w_door_ok;

  assign w_start_evt = w_stable[0] & ~r_start_prev;
  assign w_door_ok   = w_stable[1];

  // Edge detector history for the start button and the FSM state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_prev <= 1'b0;
      r_prev_ms    <= C_MS_IDLE;
    end else begin
      r_start_prev <= w_stable[0];
      r_prev_ms    <= machine_state;
    end
  end

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_fault_code;
  logic [1:0]       w_next_code;

  // State register and per-state counter, which restarts on every state entry
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CTRL_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= (w_next_state != r_state) ? '0 : r_cnt + C_CNT_ONE;
    end
  end

  // Next-state logic; fault conditions are tested before any other exit
  always_comb begin
    w_next_state = r_state;
    w_next_code  = r_fault_code;
    case (r_state)
      CTRL_IDLE: begin
        if (w_start_evt && w_door_ok && (machine_state == C_MS_IDLE))
          w_next_state = CTRL_LOCK;
      end
      CTRL_LOCK: begin
        if (!w_door_ok)
          w_next_state = CTRL_IDLE;
        else if (r_cnt == C_SETTLE_LAST)
          w_next_state = CTRL_START;
      end
      CTRL_START: begin
        if (!w_door_ok) begin
          w_next_state = CTRL_FAULT;
          w_next_code  = C_CODE_DOOR;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_next_state = CTRL_FAULT;
          w_next_code  = C_CODE_TIMEOUT;
        end else if (machine_state != C_MS_IDLE) begin
          w_next_state = CTRL_RUN;
        end
      end
      CTRL_RUN: begin
        if (!w_door_ok) begin
          w_next_state = CTRL_FAULT;
          w_next_code  = C_CODE_DOOR;
        end else if ((r_prev_ms == C_MS_SPIN) && (machine_state == C_MS_IDLE)) begin
          w_next_state = CTRL_UNLOCK;
        end
      end
      CTRL_UNLOCK: begin
        if (r_cnt == C_UNLOCK_LAST)
          w_next_state = CTRL_IDLE;
      end
      CTRL_FAULT: begin
        // The clearing press only returns to idle; a fresh press starts a cycle
        if (w_start_evt && w_door_ok && (machine_state == C_MS_IDLE)) begin
          w_next_state = CTRL_IDLE;
          w_next_code  = C_CODE_NONE;
        end
      end
      default: begin
        w_next_state = CTRL_IDLE;
        w_next_code  = C_CODE_NONE;
      end
    endcase
  end

  logic w_start;
  logic w_lock;
  logic w_busy;
  logic w_done;
  logic w_fault;
  logic w_door_closed;
  logic w_cycle_end;

  // Output decode from the upcoming state so registered outputs switch with the transition
  always_comb begin
    w_start       = (w_next_state == CTRL_START);
    w_lock        = (w_next_state == CTRL_LOCK)  || (w_next_state == CTRL_START) ||
                    (w_next_state == CTRL_RUN)   || (w_next_state == CTRL_UNLOCK);
    w_busy        = (w_next_state != CTRL_IDLE) && (w_next_state != CTRL_FAULT);
    w_done        = (r_state == CTRL_UNLOCK) && (w_next_state == CTRL_IDLE);
    w_fault       = (w_next_state == CTRL_FAULT);
    w_door_closed = w_door_ok && (w_next_state != CTRL_FAULT);
    w_cycle_end   = (r_state == CTRL_RUN) && (w_next_state == CTRL_UNLOCK);
  end

  logic       r_start;
  logic       r_lock;
  logic       r_busy;
  logic       r_done;
  logic       r_fault;
  logic       r_door_closed;
  logic [7:0] r_cycles;

  // Output registers, fault code holder and saturating completed-cycle counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start       <= 1'b0;
      r_lock        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_fault       <= 1'b0;
      r_door_closed <= 1'b0;
      r_fault_code  <= C_CODE_NONE;
      r_cycles      <= 8'd0;
    end else begin
      r_start       <= w_start;
      r_lock        <= w_lock;
      r_busy        <= w_busy;
      r_done        <= w_done;
      r_fault       <= w_fault;
      r_door_closed <= w_door_closed;
      r_fault_code  <= w_next_code;
      if (w_cycle_end && (r_cycles != C_CYCLES_MAX))
        r_cycles <= r_cycles + 8'd1;
    end
  end

  assign start       = r_start;
  assign door_closed = r_door_closed;
  assign door_lock   = r_lock;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign cycles_done = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_wash_start_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wash_start_ctrl
// Brief    : Self-checking bench for wash_start_ctrl. Stimulus pushes expected
//            results into a scoreboard queue; observed DUT behaviour pops them.
//            Latencies are counted in clock edges from the first edge that
//            samples the changed raw input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wash_start_ctrl;

  localparam int DEB    = 16;
  localparam int SETTLE = 4;
  localparam int UNLOCK = 8;
  localparam int TMO    = 32;

  localparam int SIG_LOCK  = 0;
  localparam int SIG_START = 1;
  localparam int SIG_FAULT = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start_btn_raw = 1'b0;
  logic       door_sensor_raw = 1'b0;
  logic [1:0] machine_state = 2'b00;
  logic       start;
  logic       door_closed;
  logic       door_lock;
  logic       busy;
  logic       done;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] cycles_done;

  int n_tests = 0;
  int n_fail  = 0;
  int completions = 0;

  typedef struct {
    string tag;
    int    val;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  wash_start_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .LOCK_SETTLE     (SETTLE),
    .UNLOCK_DELAY    (UNLOCK),
    .START_TIMEOUT   (TMO)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start_btn_raw   (start_btn_raw),
    .door_sensor_raw (door_sensor_raw),
    .machine_state   (machine_state),
    .start           (start),
    .door_closed     (door_closed),
    .door_lock       (door_lock),
    .busy            (busy),
    .done            (done),
    .fault           (fault),
    .fault_code      (fault_code),
    .cycles_done     (cycles_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic sb_check(input int got);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'(exp_q.size()), 1);
    end else begin
      e = exp_q.pop_front();
      chk(e.tag, 32'(got), 32'(e.val));
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      SIG_LOCK:  return door_lock;
      SIG_START: return start;
      SIG_FAULT: return fault;
      default:   return busy;
    endcase
  endfunction

  function automatic logic [14:0] outs();
    return {start, door_closed, door_lock, busy, done, fault, fault_code, cycles_done};
  endfunction

  // Count falling edges until the chosen output reaches val; expired budget is a failure
  task automatic wait_sig(input int sel, input logic val, input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (sig(sel) === val) break;
      if (n >= budget) begin
        chk($sformatf("wait_timeout_sig%0d", sel), 32'(n), 32'(-1));
        break;
      end
    end
  endtask

  // One complete wash: press, start handshake, WASH/RINSE/SPIN, unlock
  task automatic run_cycle();
    int n;
    int hold;
    int dpulse;
    start_btn_raw = 1'b1;
    sb_push("lock_latency", DEB + 1);
    sb_push("start_after_lock", SETTLE);
    wait_sig(SIG_LOCK, 1'b1, 60, n);
    sb_check(n - 1);
    wait_sig(SIG_START, 1'b1, 20, n);
    sb_check(n);
    machine_state = 2'b01;
    start_btn_raw = 1'b0;
    sb_push("start_drop", 1);
    wait_sig(SIG_START, 1'b0, 10, n);
    sb_check(n);
    chk("run_busy", 32'(busy), 1);
    chk("run_lock", 32'(door_lock), 1);
    chk("run_door_closed", 32'(door_closed), 1);
    repeat (3) @(negedge clk);
    machine_state = 2'b10;
    repeat (3) @(negedge clk);
    machine_state = 2'b11;
    repeat (2) @(negedge clk);
    machine_state = 2'b00;
    completions++;
    sb_push("unlock_hold", UNLOCK);
    sb_push("done_pulse", 1);
    sb_push("cycles_done", (completions > 255) ? 255 : completions);
    hold = 0;
    forever begin
      @(negedge clk);
      if (door_lock !== 1'b1) break;
      hold++;
      if (hold >= 30) break;
    end
    dpulse = int'(done);
    @(negedge clk);
    dpulse += int'(done);
    sb_check(hold);
    sb_check(dpulse);
    sb_check(int'(cycles_done));
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    int bad;
    int saw_lock;
    int saw_start;
    int lock_cnt;

    // Reset state
    reset_n = 1'b0;
    door_sensor_raw = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(outs()), 0);
    reset_n = 1'b1;
    repeat (DEB + 4) @(negedge clk);
    chk("door_closed_debounced", 32'(door_closed), 1);
    chk("idle_lock", 32'(door_lock), 0);
    chk("idle_busy", 32'(busy), 0);

    // Happy path
    run_cycle();

    // Bounce rejection: start toggles every 5 cycles
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      start_btn_raw = ~start_btn_raw;
      repeat (5) begin
        @(negedge clk);
        if (door_lock || start || busy) bad++;
      end
    end
    start_btn_raw = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (door_lock || start || busy) bad++;
    end
    chk("bounce_glitches", 32'(bad), 0);

    // Door opened while in CTRL_LOCK
    start_btn_raw = 1'b1;
    repeat (2) @(negedge clk);
    door_sensor_raw = 1'b0;
    sb_push("lockabort_saw_lock", 1);
    sb_push("lockabort_lock_cycles", 2);
    sb_push("lockabort_saw_start", 0);
    sb_push("lockabort_fault", 0);
    sb_push("lockabort_lock_end", 0);
    saw_lock = 0;
    saw_start = 0;
    lock_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 20) start_btn_raw = 1'b0;
      if (door_lock) begin
        saw_lock = 1;
        lock_cnt++;
      end
      if (start) saw_start = 1;
    end
    sb_check(saw_lock);
    sb_check(lock_cnt);
    sb_check(saw_start);
    sb_check(int'(fault));
    sb_check(int'(door_lock));
    door_sensor_raw = 1'b1;
    repeat (DEB + 6) @(negedge clk);

    // Door opened during WASH -> door-forced fault
    start_btn_raw = 1'b1;
    wait_sig(SIG_START, 1'b1, 60, n);
    machine_state = 2'b01;
    start_btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    door_sensor_raw = 1'b0;
    sb_push("door_fault_latency", DEB + 1);
    sb_push("door_fault_code", 1);
    sb_push("door_fault_lock", 0);
    sb_push("door_fault_door_closed", 0);
    sb_push("door_fault_busy", 0);
    wait_sig(SIG_FAULT, 1'b1, 40, n);
    sb_check(n - 1);
    sb_check(int'(fault_code));
    sb_check(int'(door_lock));
    sb_check(int'(door_closed));
    sb_check(int'(busy));
    machine_state = 2'b00;
    door_sensor_raw = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    chk("fault_held", 32'(fault), 1);
    chk("fault_code_held", 32'(fault_code), 1);
    // Clearing press
    start_btn_raw = 1'b1;
    wait_sig(SIG_FAULT, 1'b0, 40, n);
    chk("clear_code", 32'(fault_code), 0);
    saw_start = 0;
    saw_lock = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (i == 5) start_btn_raw = 1'b0;
      if (start) saw_start = 1;
      if (door_lock) saw_lock = 1;
    end
    chk("clear_no_start", 32'(saw_start), 0);
    chk("clear_no_lock", 32'(saw_lock), 0);
    repeat (DEB + 4) @(negedge clk);
    // Second press starts normally
    run_cycle();

    // Start timeout: FSM never leaves IDLE
    start_btn_raw = 1'b1;
    wait_sig(SIG_START, 1'b1, 60, n);
    start_btn_raw = 1'b0;
    sb_push("start_high_cycles", TMO);
    sb_push("timeout_fault", 1);
    sb_push("timeout_code", 2);
    sb_push("timeout_lock", 0);
    cnt = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!start) break;
      cnt++;
    end
    sb_check(cnt);
    sb_check(int'(fault));
    sb_check(int'(fault_code));
    sb_check(int'(door_lock));
    repeat (DEB + 4) @(negedge clk);
    start_btn_raw = 1'b1;
    wait_sig(SIG_FAULT, 1'b0, 40, n);
    start_btn_raw = 1'b0;
    chk("timeout_clear_code", 32'(fault_code), 0);
    repeat (DEB + 4) @(negedge clk);

    // Saturation of the completed-cycle counter
    while (completions < 255) run_cycle();
    chk("cycles_at_255", 32'(cycles_done), 255);
    run_cycle();
    chk("cycles_saturated", 32'(cycles_done), 255);

    // Asynchronous reset in the middle of RUN
    start_btn_raw = 1'b1;
    wait_sig(SIG_START, 1'b1, 60, n);
    machine_state = 2'b01;
    start_btn_raw = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_lock", 32'(door_lock), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'(outs()), 0);
    @(negedge clk);
    chk("reset_held_outputs", 32'(outs()), 0);
    machine_state = 2'b00;
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'(outs()), 0);

    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
